// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// bus-event codes and the payload byte limit.
package i2c_pkg;

  localparam int I2C_MAX_NBY = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_STOP
  } bus_ev_t;

  function automatic logic [2:0] sat_nby(input logic [2:0] n);
    return (n > 3'(I2C_MAX_NBY)) ? 3'(I2C_MAX_NBY) : n;
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Payload-side interface of the I2C target. rx_valid_o is a one-cycle
// strobe with no back-pressure; rx_data_o/rx_nby_o hold until the next strobe.
interface i2c_target_if;
  import i2c_pkg::*;

  logic [31:0] tx_data_i;
  logic [2:0]  tx_nby_i;
  logic [31:0] rx_data_o;
  logic [2:0]  rx_nby_o;
  logic        rx_valid_o;
  logic        busy_o;
  state_t      dbg_state;

  modport slave (
    input  tx_data_i, tx_nby_i,
    output rx_data_o, rx_nby_o, rx_valid_o, busy_o, dbg_state
  );

  modport master (
    output tx_data_i, tx_nby_i,
    input  rx_data_o, rx_nby_o, rx_valid_o, busy_o, dbg_state
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser with rise/fall detect on the synchronised value.
// Resets to 1 so an idle (pulled-up) line produces no edge out of reset.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) pipe <= 3'b111;
    else     pipe <= {pipe[1:0], din};
  end

  assign sync = pipe[1];
  assign rise = pipe[1] & ~pipe[2];
  assign fall = ~pipe[1] & pipe[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address match, up to 4-byte write capture and
// up to 4-byte read service, both MSB-byte-first. SDA is open-drain.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  inout  wire        sda_io,
  i2c_target_if.slave host
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge u_scl (.clk(clk_i), .rst(rst_i), .din(scl_i),
                       .sync(scl_s), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk_i), .rst(rst_i), .din(sda_io),
                       .sync(sda_s), .rise(sda_rise), .fall(sda_fall));

  state_t             state, state_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [6:0]         shift, shift_n;
  logic [31:0]        rx_sr, rx_sr_n;
  logic [2:0]         rx_cnt, rx_cnt_n;
  logic [31:0]        tx_word, tx_word_n;
  logic signed [3:0]  tx_idx, tx_idx_n;
  logic               rw, rw_n;
  logic               ninth, ninth_n;
  logic               sda_low, sda_low_n;
  logic               busy, busy_n;
  logic [31:0]        rx_data, rx_data_n;
  logic [2:0]         rx_nby, rx_nby_n;
  logic               rx_valid, rx_valid_n;
  bus_ev_t            ev;
  logic [7:0]         rx_byte, tx_byte;

  assign sda_io = sda_low ? 1'b0 : 1'bz;

  always_comb begin
    ev = EV_NONE;
    if (scl_s && sda_fall)      ev = EV_START;
    else if (scl_s && sda_rise) ev = EV_STOP;
  end

  assign rx_byte = {shift, sda_s};
  assign tx_byte = (tx_idx < 0) ? 8'hFF : tx_word[{tx_idx[1:0], 3'b000} +: 8];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;  bit_cnt <= '0; shift <= '0; rx_sr <= '0; rx_cnt <= '0;
      tx_word <= '0;     tx_idx <= '0;  rw <= 1'b0;  ninth <= 1'b0;
      sda_low <= 1'b0;   busy <= 1'b0;  rx_data <= '0; rx_nby <= '0; rx_valid <= 1'b0;
    end else begin
      state <= state_n;     bit_cnt <= bit_cnt_n; shift <= shift_n; rx_sr <= rx_sr_n;
      rx_cnt <= rx_cnt_n;   tx_word <= tx_word_n; tx_idx <= tx_idx_n; rw <= rw_n;
      ninth <= ninth_n;     sda_low <= sda_low_n; busy <= busy_n;
      rx_data <= rx_data_n; rx_nby <= rx_nby_n;   rx_valid <= rx_valid_n;
    end
  end

  // ACK states use 'ninth' to tell the fall that opens the 9th clock from the one closing it.
  always_comb begin
    state_n = state;     bit_cnt_n = bit_cnt; shift_n = shift;   rx_sr_n = rx_sr;
    rx_cnt_n = rx_cnt;   tx_word_n = tx_word; tx_idx_n = tx_idx; rw_n = rw;
    ninth_n = ninth;     sda_low_n = sda_low; busy_n = busy;
    rx_data_n = rx_data; rx_nby_n = rx_nby;   rx_valid_n = 1'b0;

    if (ev != EV_NONE) begin
      if (state != ST_IDLE && rx_cnt != 3'd0) begin
        rx_data_n  = rx_sr;
        rx_nby_n   = rx_cnt;
        rx_valid_n = 1'b1;
      end
      rx_sr_n   = '0;
      rx_cnt_n  = '0;
      bit_cnt_n = '0;
      ninth_n   = 1'b0;
      sda_low_n = 1'b0;
      busy_n    = 1'b0;
      state_n   = (ev == EV_START) ? ST_ADDR : ST_IDLE;
    end else begin
      unique case (state)
        ST_ADDR: if (scl_rise) begin
          shift_n   = rx_byte[6:0];
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == ADDR) begin
              state_n = ST_ADDR_ACK;
              busy_n  = 1'b1;
              rw_n    = rx_byte[0];
              ninth_n = 1'b0;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall && !ninth) begin
            sda_low_n = 1'b1;
            if (rw) begin
              tx_word_n = host.tx_data_i;
              tx_idx_n  = $signed({1'b0, sat_nby(host.tx_nby_i)}) - 4'sd1;
            end
          end else if (scl_rise) begin
            ninth_n = 1'b1;
          end else if (scl_fall) begin
            ninth_n   = 1'b0;
            bit_cnt_n = '0;
            state_n   = rw ? ST_TX : ST_RX;
            sda_low_n = rw ? ~tx_byte[7] : 1'b0;
          end
        end
        ST_RX: if (scl_rise) begin
          shift_n   = rx_byte[6:0];
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_cnt < 3'(I2C_MAX_NBY)) begin
              rx_sr_n  = {rx_sr[23:0], rx_byte};
              rx_cnt_n = rx_cnt + 3'd1;
              state_n  = ST_RX_ACK;
              ninth_n  = 1'b0;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall && !ninth) begin
            sda_low_n = 1'b1;
          end else if (scl_rise) begin
            ninth_n = 1'b1;
          end else if (scl_fall) begin
            ninth_n   = 1'b0;
            sda_low_n = 1'b0;
            bit_cnt_n = '0;
            state_n   = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_low_n = 1'b0;
              ninth_n   = 1'b0;
              state_n   = ST_TX_ACK;
            end else begin
              sda_low_n = ~tx_byte[~bit_cnt];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ninth_n = 1'b1;
              if (tx_idx >= 0) tx_idx_n = tx_idx - 4'sd1;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end else if (scl_fall && ninth) begin
            ninth_n   = 1'b0;
            bit_cnt_n = '0;
            sda_low_n = ~tx_byte[7];
            state_n   = ST_TX;
          end
        end
        default: ;
      endcase
    end
  end

  assign host.rx_data_o  = rx_data;
  assign host.rx_nby_o   = rx_nby;
  assign host.rx_valid_o = rx_valid;
  assign host.busy_o     = busy;
  assign host.dbg_state  = state;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-level I2C master driver, a transaction-level
// reference model feeding expected queues, and a commit monitor.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam logic [6:0] TGT_ADDR = 7'h42;

  logic clk;
  logic rst;
  logic scl_m;
  logic sda_m_low;
  wire  sda;

  i2c_target_if bus ();

  assign sda = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target #(.ADDR(TGT_ADDR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .scl_i (scl_m),
    .sda_io(sda),
    .host  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int half    = 125;
  int busy_cnt = 0;

  logic [34:0] exp_q[$];      // {nby, data} of each expected commit
  logic [7:0]  exp_bus_q[$];  // expected ACK bits / read bytes in bus order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // commit monitor
  always @(negedge clk) begin
    if (bus.busy_o) busy_cnt++;
    if (!rst && bus.rx_valid_o) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_commit: unexpected rx_valid data 0x%0h nby %0d", bus.rx_data_o, bus.rx_nby_o);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("rx_data", {32'b0, bus.rx_data_o}, {32'b0, e[31:0]});
        check("rx_nby", {61'b0, bus.rx_nby_o}, {61'b0, e[34:32]});
      end
    end
  end

  // reference model
  task automatic model_write(input logic [7:0] ab, input logic [7:0] d[$]);
    int k;
    logic [31:0] data;
    if (ab[7:1] != TGT_ADDR || ab[0]) begin
      exp_bus_q.push_back(8'h01);
      return;
    end
    exp_bus_q.push_back(8'h00);
    k = 0;
    data = '0;
    foreach (d[i]) begin
      if (i < I2C_MAX_NBY) begin
        exp_bus_q.push_back(8'h00);
        data = (data << 8) | 32'(d[i]);
        k++;
      end else begin
        exp_bus_q.push_back(8'h01);
        break;
      end
    end
    if (k > 0) exp_q.push_back({3'(k), data});
  endtask

  task automatic model_read(input int m, input logic [31:0] tx, input int nby);
    int avail;
    int idx;
    avail = (nby > I2C_MAX_NBY) ? I2C_MAX_NBY : nby;
    exp_bus_q.push_back(8'h00);
    for (int i = 0; i < m; i++) begin
      idx = avail - 1 - i;
      exp_bus_q.push_back((idx >= 0) ? 8'((tx >> (8 * idx)) & 32'hFF) : 8'hFF);
    end
  endtask

  task automatic check_bus(input string name, input logic [7:0] act);
    if (exp_bus_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got 0x%0h with no expectation queued", name, act);
    end else begin
      check(name, {56'b0, act}, {56'b0, exp_bus_q.pop_front()});
    end
  endtask

  // master driver
  task automatic bus_bit(input logic b, output logic s);
    wait_clk(half / 2);
    sda_m_low = ~b;
    wait_clk(half - half / 2);
    scl_m = 1'b1;
    wait_clk(half / 2);
    s = sda;
    wait_clk(half - half / 2);
    scl_m = 1'b0;
  endtask

  task automatic bus_start;
    wait_clk(half / 2);
    sda_m_low = 1'b0;
    wait_clk(half - half / 2);
    scl_m = 1'b1;
    wait_clk(half / 2);
    sda_m_low = 1'b1;
    wait_clk(half - half / 2);
    scl_m = 1'b0;
  endtask

  task automatic bus_stop;
    wait_clk(half / 2);
    sda_m_low = 1'b1;
    wait_clk(half - half / 2);
    scl_m = 1'b1;
    wait_clk(half / 2);
    sda_m_low = 1'b0;
    wait_clk(half - half / 2);
  endtask

  task automatic write_byte(input logic [7:0] b, input string name, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
    check_bus(name, {7'b0, ack});
  endtask

  task automatic read_byte(input logic ack, input string name);
    logic s;
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      v = {v[6:0], s};
    end
    check_bus(name, v);
    bus_bit(ack, s);
  endtask

  task automatic do_write(input logic [7:0] ab, input logic [7:0] d[$], input bit end_stop);
    logic ack;
    model_write(ab, d);
    bus_start();
    write_byte(ab, "addr_ack", ack);
    if (!ack) begin
      foreach (d[i]) begin
        write_byte(d[i], "data_ack", ack);
        if (ack) break;
      end
    end
    if (end_stop) bus_stop();
  endtask

  task automatic do_read(input int m, input logic [31:0] tx, input int nby);
    logic ack;
    bus.tx_data_i = tx;
    bus.tx_nby_i  = 3'(nby);
    model_read(m, tx, nby);
    bus_start();
    write_byte({TGT_ADDR, 1'b1}, "raddr_ack", ack);
    if (!ack) begin
      for (int i = 0; i < m; i++) read_byte(i == m - 1, "read_byte");
    end
    bus_stop();
  endtask

  // watchdog
  initial begin
    #(10 * 150000);
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] dq[$];
    logic s;
    int b0;
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m_low = 1'b0;
    bus.tx_data_i = '0;
    bus.tx_nby_i = '0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);

    check("reset_sda", {63'b0, sda}, 64'd1);
    check("reset_state", {61'b0, bus.dbg_state}, {61'b0, ST_IDLE});
    check("reset_busy", {63'b0, bus.busy_o}, 64'd0);
    check("reset_valid", {63'b0, bus.rx_valid_o}, 64'd0);
    check("reset_rx_data", {32'b0, bus.rx_data_o}, 64'd0);
    check("reset_rx_nby", {61'b0, bus.rx_nby_o}, 64'd0);

    // write, 2 bytes
    b0 = busy_cnt;
    dq.delete(); dq.push_back(8'hA5); dq.push_back(8'h3C);
    do_write(8'h84, dq, 1'b1);
    check("write_busy_seen", {63'b0, busy_cnt > b0}, 64'd1);
    check("write_busy_end", {63'b0, bus.busy_o}, 64'd0);

    // address mismatch
    b0 = busy_cnt;
    dq.delete();
    do_write(8'h86, dq, 1'b1);
    check("mismatch_busy", 64'(busy_cnt - b0), 64'd0);

    // read, 2 bytes
    do_read(2, 32'h1234BEEF, 2);

    // write overrun
    dq.delete();
    dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33);
    dq.push_back(8'h44); dq.push_back(8'h55);
    do_write(8'h84, dq, 1'b1);

    // repeated START: write then read with nothing to send
    dq.delete(); dq.push_back(8'hAA);
    do_write(8'h84, dq, 1'b0);
    do_read(1, 32'hDEADBEEF, 0);

    // reset in the middle of a read byte while the target drives SDA low
    bus.tx_data_i = 32'h0;
    bus.tx_nby_i  = 3'd1;
    exp_bus_q.push_back(8'h00);
    bus_start();
    write_byte({TGT_ADDR, 1'b1}, "rst_addr_ack", s);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
    wait_clk(half / 2);
    wait_clk(half - half / 2);
    scl_m = 1'b1;
    wait_clk(half / 4);
    check("pre_reset_sda", {63'b0, sda}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_sda", {63'b0, sda}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_state", {61'b0, bus.dbg_state}, {61'b0, ST_IDLE});
    check("mid_reset_busy", {63'b0, bus.busy_o}, 64'd0);
    check("mid_reset_rx_data", {32'b0, bus.rx_data_o}, 64'd0);
    check("mid_reset_rx_nby", {61'b0, bus.rx_nby_o}, 64'd0);
    wait_clk(half / 2);
    scl_m = 1'b0;
    bus_stop();

    // randomized transactions at a faster bus clock
    half = 20;
    for (int t = 0; t < 10; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        dq.delete();
        for (int i = 0; i < $urandom_range(1, 6); i++) dq.push_back(8'($urandom));
        do_write({TGT_ADDR, 1'b0}, dq, 1'b1);
      end else if (kind == 1) begin
        do_read($urandom_range(1, 5), $urandom, $urandom_range(0, 7));
      end else begin
        logic [6:0] a;
        a = 7'($urandom);
        if (a == TGT_ADDR) a = a ^ 7'h01;
        dq.delete(); dq.push_back(8'($urandom));
        do_write({a, 1'b0}, dq, 1'b1);
      end
      check("rand_busy_end", {63'b0, bus.busy_o}, 64'd0);
    end

    wait_clk(20);
    check("commits_drained", 64'(exp_q.size()), 64'd0);
    check("bus_drained", 64'(exp_bus_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint for the bus-facing I2C master's SDA/SCL pins.
- Receives write transactions into a 32-bit receive word and serves read transactions from a 32-bit transmit word, both MSB-byte-first, matching the master's NBY byte ordering.
- Used as the on-chip partner for loop-back of the master and as the front end of simple I2C-attached peripherals.

## Interface
- `ADDR`, default 7'h42: 7-bit target address; general call is not supported.
- `clk_i` input, 1: system clock; all logic is on its rising edge.
- `rst_i` input, 1: reset, synchronous, active-high.
- `scl_i` input, 1: I2C clock from the master; asynchronous to `clk_i`.
- `sda_io` inout, 1: I2C data. Driven only as 1'b0 or 1'bz, never 1'b1.
- `tx_data_i` input, 32: read payload; byte k is bits [8k+7:8k].
- `tx_nby_i` input, 3: number of payload bytes (0-4); values above 4 are treated as 4.
- `rx_data_o` output, 32: last received write payload, right-aligned.
- `rx_nby_o` output, 3: number of bytes in `rx_data_o` (0-4).
- `rx_valid_o` output, 1: one-cycle pulse when a write payload is committed.
- `busy_o` output, 1: high from address match to STOP or repeated START.

## Operation
- **Synchronisation:** SCL and SDA each pass a 2-FF synchroniser. Edges are detected on the synchronised values.
- **Bus events:**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge.
  - SDA changes only on the SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
- **IDLE:** on START go to ADDR, clear the bit counter and clear the RX shift register and byte count.
- **ADDR:** shift in 8 bits MSB first, then compare bits [7:1] with `ADDR`.
  - Match: go to ADDR_ACK and drive SDA low for the 9th clock.
  - Mismatch: go to WAIT_STOP and leave SDA at z.
- **ADDR_ACK, write (R/W=0):** go to RX.
- **ADDR_ACK, read (R/W=1):**
  - Latch `tx_data_i`/`tx_nby_i` at the start of the 9th clock.
  - Set byte index = `tx_nby_i`−1, then go to TX.
- **RX:** shift in 8 bits, then go to RX_ACK.
  - If the byte count is below 4: shift register ← {sr[23:0], byte}, increment count, ACK (SDA low for the 9th clock), return to RX.
  - If the count is already 4: NACK (SDA z), discard the byte, go to WAIT_STOP.
- **TX:** drive bit 7..0 of byte[index], with SDA low for a 0 and z for a 1.
  - If index < 0 (byte count exhausted or `tx_nby_i`=0), send 0xFF, i.e. SDA stays z.
  - Release SDA for the 9th clock and go to TX_ACK.
- **TX_ACK:** sample SDA at the SCL rise.
  - ACK (0): decrement index, return to TX.
  - NACK (1): go to WAIT_STOP.
- **WAIT_STOP:** SDA z; leave only on STOP or START.
- **STOP in any state:** go to IDLE.
  - Commit if the transaction was a matched write with count ≥ 1: `rx_data_o` ← sr, `rx_nby_o` ← count, pulse `rx_valid_o`.
- **Repeated START in any non-IDLE state:** commit as for STOP, then go to ADDR.
- **Precedence:** START/STOP detection overrides any bit-level transition in the same cycle.

## Timing
- **Reset values:** SDA z, state IDLE, `rx_data_o`=0, `rx_nby_o`=0, `rx_valid_o`=0, `busy_o`=0, synchronisers=1.
- **Latency:**
  - Pin to synchronised signal: 2 cycles.
  - Edge detect: +1 cycle.
  - The SDA drive update lands 3 clk cycles after the physical SCL fall.
  - At the master's 125-cycle half-period this is well inside the low phase.
- **`rx_valid_o`:** asserted exactly 1 cycle, in the cycle after the STOP/START detection cycle. `rx_data_o`/`rx_nby_o` are stable from that cycle until the next commit.
- **`busy_o`:** rises in the cycle the address match is registered; falls with the return to IDLE or ADDR.
- **Reset mid-transfer:** SDA released on the next clk edge. No commit; partial data is lost.
- **Bit counter:** 3 bits, wraps 7→0 at the byte boundary.
- **Byte counter:** saturates at 4.

## Structure
- **Package `i2c_pkg`:**
  - state encodings;
  - bus-event codes (NONE, START, STOP);
  - `I2C_MAX_NBY` = 4.
- **Sub-module `i2c_sync_edge`:** 2-FF synchroniser plus rise/fall detect, reset to 1, instantiated for SCL and SDA.
- **Top level:** FSM, shift registers and counters.

## Test plan
Default `ADDR`=7'h42; master model uses a 125-cycle half-period.
1. **Write, 2 bytes:** START, 0x84, 0xA5, 0x3C, STOP → three ACKs, `rx_data_o`=0x0000A53C, `rx_nby_o`=2, one `rx_valid_o` pulse.
2. **Address mismatch:** START, 0x86, STOP → SDA z on the 9th clock, no pulse, `busy_o` stays 0.
3. **Read, 2 bytes:** `tx_data_i`=0x1234BEEF, `tx_nby_i`=2; START, 0x85, ACK, NACK, STOP → bytes 0xBE then 0xEF on SDA, SDA z after the NACK.
4. **Write overrun:** START, 0x84, 0x11, 0x22, 0x33, 0x44, 0x55, STOP → 5th byte NACKed, `rx_data_o`=0x11223344, `rx_nby_o`=4.
5. **Repeated START:** write 0xAA, then START, 0x85 read with `tx_nby_i`=0 → `rx_valid_o` pulse with 0x000000AA, read returns 0xFF.
6. **Reset mid-read:** `rst_i` during bit 3 of a TX byte → SDA z next cycle, IDLE, all outputs at reset values.
